// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/grant/response port of the memory stage.
// master = load/store unit, slave = data memory.
interface mem_stage_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int LANES = XLEN / 8;

  logic              dreq;
  logic              dgnt;
  logic [ADDR_W-1:0] daddr;
  logic [XLEN-1:0]   dwdata;
  logic [LANES-1:0]  dbe;
  logic              dwr;
  logic              drvalid;
  logic [XLEN-1:0]   drdata;

  modport master (
    output dreq, daddr, dwdata, dbe, dwr,
    input  dgnt, drvalid, drdata
  );

  modport slave (
    input  dreq, daddr, dwdata, dbe, dwr,
    output dgnt, drvalid, drdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM stage: lane-aligned loads/stores over a req/gnt/rvalid port.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_stage_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_alu_res_i,
  input  logic [XLEN-1:0] ex_mem_data_i,
  input  logic            ex_mem_rd_i,
  input  logic            ex_mem_wr_i,
  input  logic            ex_mem_signed_i,
  input  logic [1:0]      ex_mem_size_i,
  input  logic [4:0]      ex_rd_index_i,
  output logic            mem_stall_o,
  mem_stage_lsu_if.master dmem,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_index_o,
  output logic [XLEN-1:0] wb_result_o,
  output logic            misaligned_o
);
  localparam int LANES = XLEN / 8;
  localparam int OFF_W = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  state_e state_q, state_d;

  logic [1:0]       sz;
  logic [OFF_W-1:0] off_raw, amask, off_al;
  logic [LANES-1:0] lmask;
  logic             is_mem, trap, accept, go_req;
  logic             alu_done, st_done, ld_done;

  logic              wr_q, sgn_q;
  logic [1:0]        sz_q;
  logic [OFF_W-1:0]  off_q;
  logic [4:0]        rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [LANES-1:0]  be_q;

  logic [XLEN-1:0] sh, keep, ld_ext;
  logic            sbit;

  // A 32-bit core has no doubleword lane; size 3 degrades to word.
  always_comb begin
    sz = ex_mem_size_i;
    if (XLEN == 32 && ex_mem_size_i == 2'd3) sz = 2'd2;
  end

  always_comb begin
    amask = '0;
    lmask = LANES'(8'h01);
    unique case (sz)
      2'd0: begin
        amask = '0;
        lmask = LANES'(8'h01);
      end
      2'd1: begin
        amask = OFF_W'(1);
        lmask = LANES'(8'h03);
      end
      2'd2: begin
        amask = OFF_W'(3);
        lmask = LANES'(8'h0F);
      end
      default: begin
        amask = OFF_W'(7);
        lmask = LANES'(8'hFF);
      end
    endcase
  end

  assign off_raw = ex_alu_res_i[OFF_W-1:0];
  assign off_al  = off_raw & ~amask;
  assign is_mem  = ex_mem_rd_i | ex_mem_wr_i;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = is_mem & (|(off_raw & amask));
`else
  assign trap = 1'b0;
`endif

  assign accept   = ex_valid_i & (state_q == IDLE);
  assign go_req   = accept & is_mem & ~trap;
  assign alu_done = accept & (~is_mem | trap);
  assign st_done  = (state_q == REQ) & dmem.dgnt & wr_q;
  assign ld_done  = (state_q == RESP) & dmem.drvalid;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go_req) state_d = REQ;
      REQ:  if (dmem.dgnt) state_d = wr_q ? IDLE : RESP;
      RESP: if (dmem.drvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load wins over store when both are flagged.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      sz_q    <= '0;
      off_q   <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (go_req) begin
      wr_q    <= ~ex_mem_rd_i;
      sgn_q   <= ex_mem_signed_i;
      sz_q    <= sz;
      off_q   <= off_al;
      rd_q    <= ex_rd_index_i;
      addr_q  <= ADDR_W'(ex_alu_res_i) & ~ADDR_W'(LANES - 1);
      wdata_q <= ex_mem_data_i << {off_al, 3'b000};
      be_q    <= lmask << off_al;
    end
  end

  assign sh = dmem.drdata >> {off_q, 3'b000};

  always_comb begin
    keep = '1;
    sbit = 1'b0;
    unique case (sz_q)
      2'd0: begin
        keep = XLEN'(8'hFF);
        sbit = sh[7];
      end
      2'd1: begin
        keep = XLEN'(16'hFFFF);
        sbit = sh[15];
      end
      2'd2: begin
        keep = XLEN'(32'hFFFF_FFFF);
        sbit = sh[31];
      end
      default: ;
    endcase
    ld_ext = (sh & keep) | ((sgn_q & sbit) ? ~keep : '0);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wb_valid_o    <= 1'b0;
      wb_rd_index_o <= '0;
      wb_result_o   <= '0;
      misaligned_o  <= 1'b0;
    end else begin
      wb_valid_o   <= 1'b0;
      misaligned_o <= 1'b0;
      unique case (1'b1)
        alu_done: begin
          wb_valid_o    <= 1'b1;
          wb_rd_index_o <= ex_rd_index_i;
          wb_result_o   <= ex_alu_res_i;
          misaligned_o  <= trap;
        end
        st_done: begin
          wb_valid_o    <= 1'b1;
          wb_rd_index_o <= rd_q;
          wb_result_o   <= '0;
        end
        ld_done: begin
          wb_valid_o    <= 1'b1;
          wb_rd_index_o <= rd_q;
          wb_result_o   <= ld_ext;
        end
        default: ;
      endcase
    end
  end

  assign mem_stall_o = (state_q != IDLE);
  assign dmem.dreq   = (state_q == REQ);
  assign dmem.daddr  = addr_q;
  assign dmem.dwdata = wdata_q;
  assign dmem.dbe    = be_q;
  assign dmem.dwr    = wr_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu (XLEN=32 main, XLEN=64 spot check).
// Expected WB results are queued at acceptance and popped on wb_valid_o.
module tb_mem_stage_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ex_valid, ex_rd, ex_wr, ex_sgn;
  logic [31:0] ex_alu, ex_data;
  logic [1:0]  ex_size;
  logic [4:0]  ex_rdi;
  logic        stall, wb_valid, mis;
  logic [4:0]  wb_rd;
  logic [31:0] wb_res;

  logic        e64_valid, e64_rd, e64_wr, e64_sgn;
  logic [63:0] e64_alu, e64_data;
  logic [1:0]  e64_size;
  logic [4:0]  e64_rdi;
  logic        stall64, wb64_valid, mis64;
  logic [4:0]  wb64_rd;
  logic [63:0] wb64_res;

  mem_stage_lsu_if #(.XLEN(32), .ADDR_W(32)) mif ();
  mem_stage_lsu_if #(.XLEN(64), .ADDR_W(32)) mif64 ();

  mem_stage_lsu #(.XLEN(32), .ADDR_W(32)) u_dut (
    .clk_i(clk), .reset_ni(rst_n),
    .ex_valid_i(ex_valid), .ex_alu_res_i(ex_alu),
    .ex_mem_data_i(ex_data), .ex_mem_rd_i(ex_rd),
    .ex_mem_wr_i(ex_wr), .ex_mem_signed_i(ex_sgn),
    .ex_mem_size_i(ex_size), .ex_rd_index_i(ex_rdi),
    .mem_stall_o(stall), .dmem(mif.master),
    .wb_valid_o(wb_valid), .wb_rd_index_o(wb_rd),
    .wb_result_o(wb_res), .misaligned_o(mis)
  );

  mem_stage_lsu #(.XLEN(64), .ADDR_W(32)) u_dut64 (
    .clk_i(clk), .reset_ni(rst_n),
    .ex_valid_i(e64_valid), .ex_alu_res_i(e64_alu),
    .ex_mem_data_i(e64_data), .ex_mem_rd_i(e64_rd),
    .ex_mem_wr_i(e64_wr), .ex_mem_signed_i(e64_sgn),
    .ex_mem_size_i(e64_size), .ex_rd_index_i(e64_rdi),
    .mem_stall_o(stall64), .dmem(mif64.master),
    .wb_valid_o(wb64_valid), .wb_rd_index_o(wb64_rd),
    .wb_result_o(wb64_res), .misaligned_o(mis64)
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        mis;
    int          due;
  } exp_t;
  exp_t q[$];
  exp_t m;

  task automatic push(input logic [4:0] rd, input logic [31:0] res,
                      input logic mi, input int lat);
    exp_t e;
    e.rd  = rd;
    e.res = res;
    e.mis = mi;
    e.due = cyc + lat - 1;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (q.size() == 0) begin
        check("wb_spurious", 1, 0);
      end else begin
        m = q.pop_front();
        check("wb_rd", wb_rd, m.rd);
        check("wb_res", wb_res, m.res);
        check("wb_mis", mis, m.mis);
        check("wb_cycle", cyc, m.due);
      end
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic sg,
                       input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] ri);
    @(negedge clk);
    ex_valid = 1'b1; ex_rd = rd; ex_wr = wr; ex_sgn = sg;
    ex_size = sz; ex_alu = a; ex_data = d; ex_rdi = ri;
    @(posedge clk);
    #1;
    ex_valid = 1'b0; ex_rd = 1'b0; ex_wr = 1'b0;
  endtask

  task automatic req_ok(input logic [31:0] ea, input logic [3:0] ebe,
                        input logic [31:0] ewd, input logic ewr);
    check("dreq", mif.dreq, 1);
    check("daddr", mif.daddr, ea);
    check("dbe", mif.dbe, ebe);
    check("dwr", mif.dwr, ewr);
    if (ewr) check("dwdata", mif.dwdata, ewd);
  endtask

  task automatic serve(input logic [31:0] ea, input logic [3:0] ebe,
                       input logic [31:0] ewd, input logic ewr,
                       input int w, input logic ld, input int r,
                       input logic [31:0] rdata, input logic junk);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      req_ok(ea, ebe, ewd, ewr);
      check("stall_req", stall, 1);
    end
    @(negedge clk);
    req_ok(ea, ebe, ewd, ewr);
    mif.dgnt = 1'b1;
    if (junk) begin
      mif.drvalid = 1'b1;
      mif.drdata  = 32'hDEAD_BEEF;
    end
    @(posedge clk);
    #1;
    mif.dgnt = 1'b0;
    mif.drvalid = 1'b0;
    if (ld) begin
      for (int i = 0; i < r; i++) begin
        @(negedge clk);
        check("stall_resp", stall, 1);
        check("dreq_resp", mif.dreq, 0);
      end
      @(negedge clk);
      mif.drvalid = 1'b1;
      mif.drdata  = rdata;
      @(posedge clk);
      #1;
      mif.drvalid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      if (q.size() == 0) return;
    end
    check("wb_timeout", q.size(), 0);
    q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    ex_valid = 0; ex_rd = 0; ex_wr = 0; ex_sgn = 0;
    ex_size = 0; ex_alu = 0; ex_data = 0; ex_rdi = 0;
    e64_valid = 0; e64_rd = 0; e64_wr = 0; e64_sgn = 0;
    e64_size = 0; e64_alu = 0; e64_data = 0; e64_rdi = 0;
    mif.dgnt = 0; mif.drvalid = 0; mif.drdata = 0;
    mif64.dgnt = 0; mif64.drvalid = 0; mif64.drdata = 0;
    repeat (2) @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_dreq", mif.dreq, 0);
    check("rst_daddr", mif.daddr, 0);
    check("rst_dbe", mif.dbe, 0);
    check("rst_dwdata", mif.dwdata, 0);
    check("rst_dwr", mif.dwr, 0);
    check("rst_wbv", wb_valid, 0);
    check("rst_wbres", wb_res, 0);
    check("rst_mis", mis, 0);
    check("rst_dbe64", mif64.dbe, 0);
    rst_n = 1'b1;

    issue(0, 0, 0, 0, 32'h1234_5678, 0, 5'd3);
    push(5'd3, 32'h1234_5678, 0, 1);
    drain();

    @(negedge clk);
    ex_valid = 1; ex_alu = 32'hA1A1_0001; ex_rdi = 5'd4;
    @(posedge clk);
    #1;
    push(5'd4, 32'hA1A1_0001, 0, 1);
    ex_alu = 32'hB2B2_0002; ex_rdi = 5'd5;
    @(posedge clk);
    #1;
    push(5'd5, 32'hB2B2_0002, 0, 1);
    ex_valid = 0;
    drain();

    issue(1, 0, 1, 0, 32'h103, 0, 5'd10);
    push(5'd10, 32'hFFFF_FF80, 0, 3);
    serve(32'h100, 4'b1000, 0, 0, 0, 1, 0, 32'h80FF_1234, 0);
    drain();

    issue(1, 0, 0, 1, 32'h102, 0, 5'd11);
    push(5'd11, 32'h0000_BEEF, 0, 6);
    serve(32'h100, 4'b1100, 0, 0, 1, 1, 2, 32'hBEEF_0000, 1);
    drain();

    issue(1, 0, 1, 1, 32'h100, 0, 5'd12);
    push(5'd12, 32'hFFFF_8001, 0, 3);
    serve(32'h100, 4'b0011, 0, 0, 0, 1, 0, 32'h1234_8001, 0);
    drain();

    issue(1, 0, 0, 0, 32'h101, 0, 5'd13);
    push(5'd13, 32'h0000_00F0, 0, 3);
    serve(32'h100, 4'b0010, 0, 0, 0, 1, 0, 32'h0000_F000, 0);
    drain();

    issue(1, 0, 1, 2, 32'h104, 0, 5'd14);
    push(5'd14, 32'hCAFE_F00D, 0, 3);
    serve(32'h104, 4'b1111, 0, 0, 0, 1, 0, 32'hCAFE_F00D, 0);
    drain();

    issue(1, 0, 1, 3, 32'h108, 0, 5'd15);
    push(5'd15, 32'h89AB_CDEF, 0, 3);
    serve(32'h108, 4'b1111, 0, 0, 0, 1, 0, 32'h89AB_CDEF, 0);
    drain();

    issue(1, 1, 0, 2, 32'h10C, 32'hFFFF_FFFF, 5'd16);
    push(5'd16, 32'h1357_2468, 0, 3);
    serve(32'h10C, 4'b1111, 0, 0, 0, 1, 0, 32'h1357_2468, 0);
    drain();

    issue(1, 0, 0, 2, 32'h102, 0, 5'd17);
`ifdef MEM_MISALIGN_TRAP_EN
    push(5'd17, 32'h0000_0102, 1, 1);
    @(negedge clk);
    check("trap_dreq", mif.dreq, 0);
    check("trap_stall", stall, 0);
`else
    push(5'd17, 32'h1122_3344, 0, 3);
    serve(32'h100, 4'b1111, 0, 0, 0, 1, 0, 32'h1122_3344, 0);
`endif
    drain();

    issue(0, 1, 0, 0, 32'h101, 32'h0000_00AB, 5'd20);
    push(5'd20, 32'h0, 0, 5);
    ex_valid = 1; ex_alu = 32'h5555_AAAA; ex_rdi = 5'd21;
    serve(32'h100, 4'b0010, 32'h0000_AB00, 1, 3, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    push(5'd21, 32'h5555_AAAA, 0, 1);
    ex_valid = 0;
    drain();

    issue(0, 1, 0, 1, 32'h102, 32'h0000_1234, 5'd22);
    push(5'd22, 32'h0, 0, 2);
    serve(32'h100, 4'b1100, 32'h1234_0000, 1, 0, 0, 0, 0, 0);
    drain();

    issue(0, 1, 0, 2, 32'h100, 32'hA55A_5AA5, 5'd23);
    push(5'd23, 32'h0, 0, 3);
    serve(32'h100, 4'b1111, 32'hA55A_5AA5, 1, 1, 0, 0, 0, 0);
    drain();

    issue(0, 1, 0, 2, 32'h200, 32'h7777_7777, 5'd25);
    @(negedge clk);
    check("arst_req_pre", mif.dreq, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req_dreq", mif.dreq, 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(1, 0, 0, 2, 32'h100, 0, 5'd24);
    @(negedge clk);
    mif.dgnt = 1'b1;
    @(posedge clk);
    #1;
    mif.dgnt = 1'b0;
    #2;
    check("arst_resp_pre", stall, 1);
    rst_n = 1'b0;
    #1;
    check("arst_dreq", mif.dreq, 0);
    check("arst_stall", stall, 0);
    check("arst_daddr", mif.daddr, 0);
    check("arst_dbe", mif.dbe, 0);
    check("arst_dwr", mif.dwr, 0);
    check("arst_wbv", wb_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mif.drvalid = 1'b1;
    mif.drdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    mif.drvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("arst_nowb", wb_valid, 0);
      check("arst_idle", stall, 0);
    end

    issue(0, 0, 0, 0, 32'h0BAD_F00D, 0, 5'd26);
    push(5'd26, 32'h0BAD_F00D, 0, 1);
    drain();

    @(negedge clk);
    e64_valid = 1; e64_rd = 1; e64_sgn = 1; e64_size = 2'd2;
    e64_alu = 64'h104; e64_rdi = 5'd9;
    @(posedge clk);
    #1;
    e64_valid = 0;
    @(negedge clk);
    check("x64_dreq", mif64.dreq, 1);
    check("x64_daddr", mif64.daddr, 64'h100);
    check("x64_dbe", mif64.dbe, 64'hF0);
    check("x64_dwr", mif64.dwr, 0);
    mif64.dgnt = 1'b1;
    @(posedge clk);
    #1;
    mif64.dgnt = 1'b0;
    @(negedge clk);
    mif64.drvalid = 1'b1;
    mif64.drdata  = 64'h8000_0000_0000_0000;
    @(posedge clk);
    #1;
    mif64.drvalid = 1'b0;
    @(negedge clk);
    check("x64_wbv", wb64_valid, 1);
    check("x64_res", wb64_res, 64'hFFFF_FFFF_8000_0000);
    check("x64_rd", wb64_rd, 5'd9);
    check("x64_mis", mis64, 0);
    @(negedge clk);
    check("x64_wbv_once", wb64_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
